mix_frame_sequencer: RTL and testbench
======================================

Name: mix_frame_sequencer

Overview:
- Sequences the per-sample voice/oscillator/envelope time-multiplex that feeds the volume mixer and envelope pipeline.
- On each sample tick it sweeps the slot counter xxxx over all VOICES*V_ENVS slots, then drains the pipeline.
- Generates the voice/osc shift strobes (sh_voice_reg, sh_osc_reg) and the delayed osc index line (ox_dly).
- Flags frame completion and counts sample ticks lost to overrun.

Parameters:
- VOICES, 8, voices per frame
- V_OSC, 4, oscillators per voice
- O_ENVS, 2, envelopes per oscillator
- V_WIDTH, utils::clogb2(VOICES), voice index width
- O_WIDTH, utils::clogb2(V_OSC), osc index width
- OE_WIDTH, utils::clogb2(O_ENVS), env-in-osc index width
- E_WIDTH, O_WIDTH+OE_WIDTH, env-in-voice index width
- V_ENVS, V_OSC*O_ENVS, envelopes per voice
- DLY_DEPTH, 4, number of ox_dly taps
- FLUSH_CYCLES, V_OSC+3, drain cycles after the last slot

Ports:
- sCLK_XVXENVS  in  1  clock
- reset  in  1  synchronous active-high reset
- sample_tick  in  1  one-cycle frame start request
- xxxx  out  V_WIDTH+E_WIDTH  slot counter {voice, osc, env}
- vx  out  V_WIDTH  current voice, equals xxxx[V_WIDTH+E_WIDTH-1:E_WIDTH]
- ox  out  O_WIDTH  current osc, equals xxxx[E_WIDTH-1:OE_WIDTH]
- ox_dly  out  O_WIDTH x DLY_DEPTH (unpacked)  delayed osc index taps
- sh_voice_reg  out  V_OSC+3  voice-start strobe shift register
- sh_osc_reg  out  V_ENVS+1  osc-start strobe shift register
- busy  out  1  high in RUN or FLUSH
- frame_done  out  1  one-cycle pulse at end of FLUSH
- overrun_cnt  out  8  saturating count of dropped ticks

Behaviour:
- Constants: TOTAL = VOICES*V_ENVS; LAST = TOTAL-1.
- Reset values: state=IDLE, xxxx=LAST, sh_voice_reg=0, sh_osc_reg=0, all ox_dly taps=0, busy=0, frame_done=0, overrun_cnt=0.
- xxxx parks at LAST so no zero-based mixer decode fires while idle.
- Reset mid-frame aborts the frame immediately; no frame_done is issued.
- FSM states:
  - IDLE: sample_tick -> RUN, with xxxx=0 on the next cycle.
  - RUN: xxxx increments by 1 each cycle. At xxxx==LAST, next state is FLUSH, and xxxx holds LAST.
  - FLUSH: counts FLUSH_CYCLES cycles with xxxx=LAST. On the last flush cycle, frame_done=1 for one cycle, then -> IDLE.
- sample_tick while busy: ignored, and overrun_cnt increments, saturating at 255.
- sample_tick on the same cycle as frame_done: it is also dropped and counted. The frame is back in IDLE on the next cycle.
- The counter wraps only by the RUN->FLUSH transition; it never wraps to 0 inside a frame.
- Strobe sources, from the registered xxxx value:
  - v_start = RUN && xxxx[E_WIDTH-1:0]==0
  - o_start = RUN && xxxx[OE_WIDTH-1:0]==0
- Shift registers, each clock:
  - sh_voice_reg <= {sh_voice_reg[V_OSC+1:0], v_start}
  - sh_osc_reg <= {sh_osc_reg[V_ENVS-1:0], o_start}
  - Bit k is therefore asserted k+1 clocks after the slot that generated it.
  - Shifting continues in FLUSH and IDLE with 0 shifted in, so both registers are 0 after FLUSH. FLUSH_CYCLES must be ≥ V_OSC+3.
- ox_dly:
  - ox_dly[0] <= ox
  - ox_dly[k] <= ox_dly[k-1] for k = 1..DLY_DEPTH-1
  - Updated every clock, in all states.
- Per frame in RUN: exactly VOICES v_start pulses and VOICES*V_OSC o_start pulses.
- Frame length from tick to frame_done: 1 + TOTAL + FLUSH_CYCLES cycles (72 at defaults).
- busy=1 from the first RUN cycle through the frame_done cycle inclusive.
- All outputs are registered; vx and ox are direct slices of registered xxxx.

Test Plan:
- Reset then idle 10 cycles:
  - xxxx=63, busy=0, both shift registers 0, overrun_cnt=0.
- Single tick (defaults):
  - xxxx runs 0..63 in consecutive cycles, then holds 63 for 7 cycles.
  - frame_done is pulsed once, 71 cycles after the xxxx=0 cycle.
  - 8 v_start pulses at xxxx=0,8,…,56; 32 o_start pulses at even xxxx.
- Strobe alignment:
  - sh_voice_reg[2] is high exactly 3 cycles after each xxxx value with low 3 bits 0 (xxxx=0,8,16,…).
  - sh_osc_reg[3] is high 4 cycles after each even xxxx.
  - ox_dly[1] equals ox from 2 cycles earlier.
- Overrun:
  - 3 ticks during RUN plus 1 tick on the frame_done cycle -> overrun_cnt=4, and the frame is not restarted.
  - 300 ticks while busy -> overrun_cnt=255.
- Reset mid-frame at xxxx=20:
  - Next cycle: xxxx=63, IDLE, no frame_done.
  - A following tick starts a clean frame from xxxx=0.
- Back-to-back:
  - A tick the cycle after frame_done starts the next frame.
  - Its xxxx=0 cycle comes exactly 73 cycles after the previous frame's xxxx=0 cycle.

Source files
------------

// File: rtl/mix_frame_sequencer_if.sv
// Shared width helper and the sample-tick / mixer-timing bundle between the
// frame sequencer and the volume mixer / envelope pipeline it drives.

package utils;
    // Bits needed to index n items (at least 1).
    function automatic int clogb2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

interface mix_frame_sequencer_if #(
    parameter int VOICES    = 8,
    parameter int V_OSC     = 4,
    parameter int O_ENVS    = 2,
    parameter int DLY_DEPTH = 4
);
    localparam int V_WIDTH  = utils::clogb2(VOICES);
    localparam int O_WIDTH  = utils::clogb2(V_OSC);
    localparam int OE_WIDTH = utils::clogb2(O_ENVS);
    localparam int E_WIDTH  = O_WIDTH + OE_WIDTH;
    localparam int V_ENVS   = V_OSC * O_ENVS;

    logic                        sample_tick;
    logic [V_WIDTH+E_WIDTH-1:0]  xxxx;
    logic [V_WIDTH-1:0]          vx;
    logic [O_WIDTH-1:0]          ox;
    logic [O_WIDTH-1:0]          ox_dly [DLY_DEPTH];
    logic [V_OSC+2:0]            sh_voice_reg;
    logic [V_ENVS:0]             sh_osc_reg;
    logic                        busy;
    logic                        frame_done;
    logic [7:0]                  overrun_cnt;

    // Frame requester / timing consumer side.
    modport master (
        output sample_tick,
        input  xxxx, vx, ox, ox_dly, sh_voice_reg, sh_osc_reg,
               busy, frame_done, overrun_cnt
    );

    // Sequencer side.
    modport slave (
        input  sample_tick,
        output xxxx, vx, ox, ox_dly, sh_voice_reg, sh_osc_reg,
               busy, frame_done, overrun_cnt
    );
endinterface

// File: rtl/mix_frame_sequencer.sv
// Per-sample slot sequencer: on each sample tick sweeps the {voice,osc,env}
// slot counter over one frame, drains the downstream pipeline, and produces
// the voice/osc start strobe shift registers and the delayed osc index taps.

module mix_frame_sequencer #(
    parameter int VOICES       = 8,
    parameter int V_OSC        = 4,
    parameter int O_ENVS       = 2,
    parameter int V_WIDTH      = utils::clogb2(VOICES),
    parameter int O_WIDTH      = utils::clogb2(V_OSC),
    parameter int OE_WIDTH     = utils::clogb2(O_ENVS),
    parameter int E_WIDTH      = O_WIDTH + OE_WIDTH,
    parameter int V_ENVS       = V_OSC * O_ENVS,
    parameter int DLY_DEPTH    = 4,
    parameter int FLUSH_CYCLES = V_OSC + 3
) (
    input  logic                   sCLK_XVXENVS,
    input  logic                   reset,
    mix_frame_sequencer_if.slave   bus
);
    localparam int XW    = V_WIDTH + E_WIDTH;
    localparam int TOTAL = VOICES * V_ENVS;
    localparam int FW    = utils::clogb2(FLUSH_CYCLES + 1);

    localparam logic [XW-1:0] LAST_SLOT  = XW'(TOTAL - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q;
    logic [XW-1:0]       xxxx_q;
    logic [FW-1:0]       flush_q;
    logic                busy_q;
    logic                frame_done_q;
    logic [7:0]          overrun_q;
    logic [V_OSC+2:0]    sh_voice_q;
    logic [V_ENVS:0]     sh_osc_q;
    logic [O_WIDTH-1:0]  ox_dly_q [DLY_DEPTH];

    logic                v_start;
    logic                o_start;
    logic [O_WIDTH-1:0]  ox_cur;

    assign ox_cur  = xxxx_q[E_WIDTH-1:OE_WIDTH];
    assign v_start = (state_q == RUN) && (xxxx_q[E_WIDTH-1:0] == '0);
    assign o_start = (state_q == RUN) && (xxxx_q[OE_WIDTH-1:0] == '0);

    // Frame FSM: idle parked at the last slot, sweep all slots, then drain.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            state_q      <= IDLE;
            xxxx_q       <= LAST_SLOT;
            flush_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values; the default below is overridden later in the block.
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.sample_tick) begin
                        state_q <= RUN;
                        xxxx_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (xxxx_q == LAST_SLOT) begin
                        state_q <= FLUSH;
                        flush_q <= '0;
                    end else begin
                        xxxx_q <= xxxx_q + 1'b1;
                    end
                end
                FLUSH: begin
                    if (frame_done_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        flush_q <= flush_q + 1'b1;
                        if (flush_q == FLUSH_LAST) begin
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    xxxx_q  <= LAST_SLOT;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Count sample ticks that arrive while a frame is still in progress.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            overrun_q <= '0;
        end else if (bus.sample_tick && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
        end
    end

    // Start strobe shift registers and osc index delay line, clocked in all states.
    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            sh_voice_q <= '0;
            sh_osc_q   <= '0;
            // NOTE: this delay line is a handful of flops, not a RAM, and its
            // reset value is visible downstream, so it is reset like any register.
            for (int k = 0; k < DLY_DEPTH; k++) begin
                ox_dly_q[k] <= '0;
            end
        end else begin
            sh_voice_q  <= {sh_voice_q[V_OSC+1:0], v_start};
            sh_osc_q    <= {sh_osc_q[V_ENVS-1:0], o_start};
            ox_dly_q[0] <= ox_cur;
            for (int k = 1; k < DLY_DEPTH; k++) begin
                ox_dly_q[k] <= ox_dly_q[k-1];
            end
        end
    end

    assign bus.xxxx         = xxxx_q;
    assign bus.vx           = xxxx_q[XW-1:E_WIDTH];
    assign bus.ox           = ox_cur;
    assign bus.ox_dly       = ox_dly_q;
    assign bus.sh_voice_reg = sh_voice_q;
    assign bus.sh_osc_reg   = sh_osc_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_mix_frame_sequencer.sv
// Directed bench for mix_frame_sequencer at default parameters.

module tb_mix_frame_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mix_frame_sequencer_if #(.VOICES(8), .V_OSC(4), .O_ENVS(2), .DLY_DEPTH(4)) bus ();

    mix_frame_sequencer dut (
        .sCLK_XVXENVS (clk),
        .reset        (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected timeline of one frame; cycle 1 is the first RUN cycle.
    function automatic int mx(input int c);
        if (c >= 1 && c <= 64) return c - 1;
        return 63;
    endfunction

    function automatic bit mrun(input int c);
        return (c >= 1 && c <= 64);
    endfunction

    function automatic bit mvs(input int c);
        return mrun(c) && (mx(c) % 8 == 0);
    endfunction

    function automatic bit mos(input int c);
        return mrun(c) && (mx(c) % 2 == 0);
    endfunction

    function automatic int mox(input int c);
        return (mx(c) / 2) % 4;
    endfunction

    initial begin
        int vpulses;
        int opulses;
        int dpulses;
        int waited;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.sample_tick = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset state after 10 idle cycles.
        step(10);
        check("rst_xxxx", bus.xxxx, 63);
        check("rst_vx", bus.vx, 7);
        check("rst_ox", bus.ox, 3);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_shv", bus.sh_voice_reg, 0);
        check("rst_sho", bus.sh_osc_reg, 0);
        check("rst_ovr", bus.overrun_cnt, 0);
        check("rst_oxdly3", bus.ox_dly[3], 3);

        // Single frame: full timeline of counter, strobes and delay taps.
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        vpulses = 0;
        opulses = 0;
        dpulses = 0;
        for (int c = 1; c <= 75; c++) begin
            check($sformatf("f_xxxx_c%0d", c), bus.xxxx, mx(c));
            check($sformatf("f_vx_c%0d", c), bus.vx, mx(c) / 8);
            check($sformatf("f_ox_c%0d", c), bus.ox, mox(c));
            check($sformatf("f_busy_c%0d", c), bus.busy, (c <= 72));
            check($sformatf("f_done_c%0d", c), bus.frame_done, (c == 72));
            check($sformatf("f_shv2_c%0d", c), bus.sh_voice_reg[2], mvs(c - 3));
            check($sformatf("f_sho3_c%0d", c), bus.sh_osc_reg[3], mos(c - 4));
            check($sformatf("f_oxdly1_c%0d", c), bus.ox_dly[1], mox(c - 2));
            vpulses += int'(bus.sh_voice_reg[0]);
            opulses += int'(bus.sh_osc_reg[0]);
            dpulses += int'(bus.frame_done);
            step();
        end
        check("f_vstart_count", vpulses, 8);
        check("f_ostart_count", opulses, 32);
        check("f_done_count", dpulses, 1);
        check("f_shv_drained", bus.sh_voice_reg, 0);
        check("f_sho_drained", bus.sh_osc_reg, 0);

        // Overrun: 3 ticks in RUN plus one on the frame_done cycle.
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            bus.sample_tick = (c == 10 || c == 20 || c == 30 || c == 72);
            if (c == 11) check("ovr_after_first", bus.overrun_cnt, 1);
            if (c == 72) check("ovr_done_cycle", bus.frame_done, 1);
            step();
        end
        bus.sample_tick = 1'b0;
        check("ovr_cnt4", bus.overrun_cnt, 4);
        check("ovr_idle_busy", bus.busy, 0);
        check("ovr_idle_xxxx", bus.xxxx, 63);
        step(7);
        check("ovr_no_restart", bus.busy, 0);
        check("ovr_cnt4_hold", bus.overrun_cnt, 4);

        // Saturation: tick held high across several frames.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("sat_rst_cnt", bus.overrun_cnt, 0);
        bus.sample_tick = 1'b1;
        step(73);
        check("sat_cnt72", bus.overrun_cnt, 72);
        check("sat_idle_gap", bus.busy, 0);
        step(330);
        check("sat_cnt255", bus.overrun_cnt, 255);
        bus.sample_tick = 1'b0;
        waited = 0;
        while (bus.busy && waited < 100) begin
            step();
            waited++;
        end
        check("sat_idle_timeout", bus.busy, 0);
        check("sat_cnt255_hold", bus.overrun_cnt, 255);

        // Reset mid-frame at xxxx=20.
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        step(20);
        check("mid_xxxx20", bus.xxxx, 20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_xxxx", bus.xxxx, 63);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.frame_done, 0);
        check("mid_rst_shv", bus.sh_voice_reg, 0);
        dpulses = 0;
        for (int c = 0; c < 80; c++) begin
            dpulses += int'(bus.frame_done) + int'(bus.busy);
            step();
        end
        check("mid_no_activity", dpulses, 0);

        // Clean frame after the abort, then a back-to-back tick.
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            check($sformatf("b_xxxx_c%0d", c), bus.xxxx, mx(c));
            check($sformatf("b_done_c%0d", c), bus.frame_done, (c == 72));
            step();
        end
        check("b2b_idle_busy", bus.busy, 0);
        check("b2b_idle_done", bus.frame_done, 0);
        bus.sample_tick = 1'b1;
        step();
        bus.sample_tick = 1'b0;
        check("b2b_xxxx0_at74", bus.xxxx, 0);
        check("b2b_busy", bus.busy, 1);
        check("b2b_ovr", bus.overrun_cnt, 0);
        step();
        check("b2b_xxxx1", bus.xxxx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
